// File: rtl/ppbuf_pkg.sv
// Shared types and helpers for the ping-pong buffer.
// Contents:
//   bank_state_t  per-bank lifecycle EMPTY -> FILLING -> FULL -> DRAINING
//   bank_idx()    joins bank select and in-bank address into a RAM address
package ppbuf_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // {bank, addr}. The result is 32 bits wide; the caller narrows it to ADDR_W+1.
  function automatic logic [31:0] bank_idx(input logic        bank,
                                           input logic [30:0] addr,
                                           input int unsigned addr_w);
    bank_idx = (32'(bank) << addr_w) | {1'b0, addr};
  endfunction

endpackage

// File: rtl/ppbuf_ram.sv
// Simple dual-port RAM holding both banks, 2*2**ADDR_W x DATA_W. It infers block RAM.
// The address MSB selects the bank. Contents are never reset.
// Ports:
//   clk    rising-edge clock
//   we     write enable;   waddr / wdata  write address / data
//   re     read enable;    raddr          read address
//   rdata  registered read data, 1-cycle latency; holds while re = 0
module ppbuf_ram
  import ppbuf_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W:0]     waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                re,
  input  logic [ADDR_W:0]     raddr,
  output logic [DATA_W-1:0]   rdata
);

  localparam int unsigned WORDS = 2 << ADDR_W;

  logic [DATA_W-1:0] mem [WORDS];

  // One write port and one read port. The two ports never address the same bank.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pingpong_buf.sv
// Two-bank ping-pong buffer. The writer fills one bank while the reader drains the other.
// The banks swap roles when a bank commits or finishes draining.
// Optional feature: define PPBUF_PARTIAL_EN to let wr_last commit a bank early.
// Ports:
//   sys_clk, sys_rst    clock, asynchronous active-high reset
//   wr_valid/wr_ready   write handshake; wr_data word; wr_last early commit
//   rd_valid/rd_ready   read handshake; rd_data word; rd_last last word of bank
//   wr_bank, rd_bank    bank owned by the writer / reader
//   bank_full[1:0]      per-bank FULL or DRAINING flag
module pingpong_buf
  import ppbuf_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic [1:0]        bank_full
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned RAM_AW = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  bank_state_t         bank_q [2];
  bank_state_t         bank_n [2];
  logic [LEN_W-1:0]    len_q  [2];
  logic [LEN_W-1:0]    len_n  [2];
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_n;
  logic                wr_bank_n;
  logic [LEN_W-1:0]    rd_cnt_q, rd_cnt_n;
  logic                rd_bank_n;
  logic                s1_valid_q, s1_valid_n;
  logic                s1_last_q, s1_last_n;
  logic                rd_valid_n, rd_last_n;
  logic [DATA_W-1:0]   rd_data_n;
  logic                wr_ready_n;
  logic [1:0]          bank_full_n;

  logic                wr_fire;
  logic                wr_commit;
  logic                early_commit;
  logic                rd_advance;
  logic                rd_owns;
  logic                rd_issue;
  logic                rd_done;
  logic [RAM_AW-1:0]   ram_waddr;
  logic [RAM_AW-1:0]   ram_raddr;
  logic [DATA_W-1:0]   ram_q;

`ifdef PPBUF_PARTIAL_EN
  assign early_commit = wr_last;
`else
  logic wr_last_unused;
  assign wr_last_unused = wr_last;
  assign early_commit   = 1'b0;
`endif

  assign wr_fire = wr_valid & wr_ready;

  assign ram_waddr = RAM_AW'(bank_idx(wr_bank, 31'(wr_addr_q), ADDR_W));
  assign ram_raddr = RAM_AW'(bank_idx(rd_bank, 31'(rd_cnt_q[ADDR_W-1:0]), ADDR_W));

  ppbuf_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (sys_clk),
    .we    (wr_fire),
    .waddr (ram_waddr),
    .wdata (wr_data),
    .re    (rd_issue),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  // Next-state logic for both bank FSMs, the writer, and the two-stage read pipeline.
  always_comb begin
    bank_n[0]   = bank_q[0];
    bank_n[1]   = bank_q[1];
    len_n[0]    = len_q[0];
    len_n[1]    = len_q[1];
    wr_addr_n   = wr_addr_q;
    wr_bank_n   = wr_bank;
    rd_cnt_n    = rd_cnt_q;
    rd_bank_n   = rd_bank;
    s1_valid_n  = s1_valid_q;
    s1_last_n   = s1_last_q;
    rd_valid_n  = rd_valid;
    rd_last_n   = rd_last;
    rd_data_n   = rd_data;
    wr_commit   = 1'b0;
    rd_advance  = 1'b0;
    rd_owns     = 1'b0;
    rd_issue    = 1'b0;
    rd_done     = 1'b0;
    wr_ready_n  = 1'b0;
    bank_full_n = 2'b00;

    // Writer: fill the current bank and commit on its last address or on an early commit.
    if (wr_fire) begin
      wr_commit = (wr_addr_q == LAST_ADDR) || early_commit;
      if (wr_commit) begin
        bank_n[wr_bank] = FULL;
        len_n[wr_bank]  = LEN_W'(wr_addr_q) + LEN_W'(1);
        wr_addr_n       = '0;
        wr_bank_n       = ~wr_bank;
      end else begin
        bank_n[wr_bank] = FILLING;
        wr_addr_n       = wr_addr_q + ADDR_W'(1);
      end
    end

    // Reader: the RAM output stage (s1) and the output register move together.
    // A read issues only when the output register will take what s1 holds now.
    rd_advance = !rd_valid || rd_ready;
    rd_owns    = (bank_q[rd_bank] == FULL) || (bank_q[rd_bank] == DRAINING);
    rd_issue   = rd_advance && rd_owns && (rd_cnt_q != len_q[rd_bank]);

    if (rd_issue) begin
      bank_n[rd_bank] = DRAINING;
      rd_cnt_n        = rd_cnt_q + LEN_W'(1);
    end

    if (rd_advance) begin
      rd_valid_n = s1_valid_q;
      rd_last_n  = s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        rd_data_n = ram_q;
      end
      s1_valid_n = rd_issue;
      s1_last_n  = rd_issue && ((rd_cnt_q + LEN_W'(1)) == len_q[rd_bank]);
    end

    // The bank is released when its last word leaves the output register.
    rd_done = rd_valid && rd_ready && rd_last;
    if (rd_done) begin
      bank_n[rd_bank] = EMPTY;
      rd_cnt_n        = '0;
      rd_bank_n       = ~rd_bank;
    end

    wr_ready_n     = (bank_n[wr_bank_n] == EMPTY) || (bank_n[wr_bank_n] == FILLING);
    bank_full_n[0] = (bank_n[0] == FULL) || (bank_n[0] == DRAINING);
    bank_full_n[1] = (bank_n[1] == FULL) || (bank_n[1] == DRAINING);
  end

  // State and output registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bank_q[0]  <= EMPTY;
      bank_q[1]  <= EMPTY;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      wr_addr_q  <= '0;
      wr_bank    <= 1'b0;
      rd_cnt_q   <= '0;
      rd_bank    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_data    <= '0;
      wr_ready   <= 1'b1;
      bank_full  <= 2'b00;
    end else begin
      bank_q[0]  <= bank_n[0];
      bank_q[1]  <= bank_n[1];
      len_q[0]   <= len_n[0];
      len_q[1]   <= len_n[1];
      wr_addr_q  <= wr_addr_n;
      wr_bank    <= wr_bank_n;
      rd_cnt_q   <= rd_cnt_n;
      rd_bank    <= rd_bank_n;
      s1_valid_q <= s1_valid_n;
      s1_last_q  <= s1_last_n;
      rd_valid   <= rd_valid_n;
      rd_last    <= rd_last_n;
      rd_data    <= rd_data_n;
      wr_ready   <= wr_ready_n;
      bank_full  <= bank_full_n;
    end
  end

endmodule

// File: tb/tb_pingpong_buf.sv
// Testbench for pingpong_buf with DATA_W = 8 and ADDR_W = 4.
// A queue-based model of committed banks predicts the handshakes, bank flags and read data.
module tb_pingpong_buf;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        bank_full;

  pingpong_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .wr_bank   (wr_bank),
    .rd_bank   (rd_bank),
    .bank_full (bank_full)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words written but not yet read, and the lengths of the committed banks.
  logic [7:0] exp_q [$];
  int         lens [$];
  int         wr_pos, rd_pos, n_commit, n_drain;
  bit         partial_en;
  bit         prev_hold;
  logic [7:0] prev_data;
  bit         stall_mon;
  int         stall_run, stall_max;

  initial begin
`ifdef PPBUF_PARTIAL_EN
    partial_en = 1'b1;
`else
    partial_en = 1'b0;
`endif
  end

  // Compare process: check every cycle, then record the transfers at the next edge.
  always @(negedge sys_clk) begin : cmp
    int         occ;
    logic [1:0] exp_full;
    if (sys_rst) begin
      exp_q.delete();
      lens.delete();
      wr_pos = 0; rd_pos = 0; n_commit = 0; n_drain = 0;
      prev_hold = 1'b0;
    end else begin
      occ = n_commit - n_drain;
      check("wr_ready", 32'(wr_ready), 32'(occ < 2));
      check("wr_bank", 32'(wr_bank), 32'(n_commit % 2));
      check("rd_bank", 32'(rd_bank), 32'(n_drain % 2));
      exp_full = (occ == 0) ? 2'b00 : (occ == 1) ? 2'(2'b01 << (n_drain % 2)) : 2'b11;
      check("bank_full", 32'(bank_full), 32'(exp_full));
      if (prev_hold) begin
        check("hold_valid", 32'(rd_valid), 32'(1));
        check("hold_data", 32'(rd_data), 32'(prev_data));
      end
      if (rd_valid) begin
        if (occ == 0 || exp_q.size() == 0 || lens.size() == 0) begin
          check("rd_valid_spurious", 32'(rd_valid), 32'(0));
        end else begin
          check("rd_data", 32'(rd_data), 32'(exp_q[0]));
          check("rd_last", 32'(rd_last), 32'(rd_pos == lens[0] - 1));
        end
      end else begin
        check("rd_last_idle", 32'(rd_last), 32'(0));
      end
      prev_hold = rd_valid && !rd_ready;
      prev_data = rd_data;

      if (rd_valid && rd_ready && exp_q.size() > 0 && lens.size() > 0) begin
        void'(exp_q.pop_front());
        rd_pos++;
        if (rd_pos == lens[0]) begin
          void'(lens.pop_front());
          rd_pos = 0;
          n_drain++;
        end
      end
      if (wr_valid && wr_ready) begin
        exp_q.push_back(wr_data);
        wr_pos++;
        if (wr_pos == DEPTH || (partial_en && wr_last)) begin
          lens.push_back(wr_pos);
          wr_pos = 0;
          n_commit++;
        end
      end
      if (stall_mon && wr_valid) begin
        if (!wr_ready) stall_run++;
        else stall_run = 0;
        if (stall_run > stall_max) stall_max = stall_run;
      end
    end
  end

  // Sink: a fixed or random rd_ready, changed just after each rising edge.
  bit rd_force = 1'b0;
  bit rd_rand  = 1'b0;
  initial rd_ready = 1'b0;
  always @(posedge sys_clk) begin
    #1;
    rd_ready = rd_rand ? ($urandom_range(0, 3) != 0) : rd_force;
  end

  task automatic send(input logic [7:0] d, input logic last);
    int t;
    t = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    @(negedge sys_clk);
    while (!wr_ready && t < 200) begin
      t++;
      @(negedge sys_clk);
    end
    if (!wr_ready) check("send_timeout", 32'(wr_ready), 32'(1));
    @(posedge sys_clk);
    #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_drain(input int limit);
    int t;
    t = 0;
    @(negedge sys_clk);
    while (exp_q.size() != 0 && t < limit) begin
      t++;
      @(negedge sys_clk);
    end
    check("drain", 32'(exp_q.size()), 32'(0));
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    sys_rst  = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst  = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    wr_last  = 1'b0;
    stall_mon = 1'b0; stall_run = 0; stall_max = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_rd_valid", 32'(rd_valid), 32'(0));
    check("rst_rd_last", 32'(rd_last), 32'(0));
    check("rst_bank_full", 32'(bank_full), 32'(0));
    check("rst_rd_data", 32'(rd_data), 32'(0));
    check("rst_wr_bank", 32'(wr_bank), 32'(0));
    check("rst_rd_bank", 32'(rd_bank), 32'(0));
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_wr_ready", 32'(wr_ready), 32'(1));
    @(posedge sys_clk);
    #1;

    // 1: a single bank with rd_valid two cycles after commit.
    rd_force = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    @(negedge sys_clk);
    check("t1_wr_bank", 32'(wr_bank), 32'(1));
    check("t1_bank_full", 32'(bank_full), 32'(2'b01));
    check("t1_rd_valid_c0", 32'(rd_valid), 32'(0));
    @(negedge sys_clk);
    check("t1_rd_valid_c1", 32'(rd_valid), 32'(0));
    @(negedge sys_clk);
    check("t1_rd_valid_c2", 32'(rd_valid), 32'(1));
    check("t1_first_data", 32'(rd_data), 32'(8'h00));
    @(posedge sys_clk);
    #1;
    wait_drain(100);
    check("t1_rd_bank", 32'(rd_bank), 32'(1));

    // 2: 48 words against a stalled sink.
    rd_force = 1'b0;
    idle(1);
    for (int i = 0; i < 32; i++) send(8'(8'h10 + i), 1'b0);
    @(negedge sys_clk);
    check("t2_wr_ready", 32'(wr_ready), 32'(0));
    check("t2_bank_full", 32'(bank_full), 32'(2'b11));
    @(posedge sys_clk);
    #1;
    rd_force = 1'b1;
    for (int i = 32; i < 48; i++) send(8'(8'h10 + i), 1'b0);
    wait_drain(200);
    check("t2_rd_bank", 32'(rd_bank), 32'(0));

    // 3: a five-cycle sink stall in the middle of a bank.
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1'b0);
    idle(5);
    rd_force = 1'b0;
    idle(5);
    rd_force = 1'b1;
    wait_drain(100);
    check("t3_rd_bank", 32'(rd_bank), 32'(1));

    // 4: continuous writes over eight banks.
    stall_mon = 1'b1; stall_run = 0; stall_max = 0;
    for (int i = 0; i < 128; i++) send(8'(i * 3 + 1), 1'b0);
    stall_mon = 1'b0;
    wait_drain(200);
    check("t4_max_stall", 32'(stall_max <= 2), 32'(1));
    check("t4_rd_bank", 32'(rd_bank), 32'(1));

    // Random traffic: random gaps, random wr_last and a random sink.
    rd_rand = 1'b1;
    for (int i = 0; i < 160; i++) begin
      send(8'($urandom), (i == 159) || ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rd_rand  = 1'b0;
    rd_force = 1'b1;
    wait_drain(400);

    // 5: reset while bank 1 is filling and bank 0 is full.
    do_reset();
    rd_force = 1'b0;
    idle(1);
    for (int i = 0; i < 16; i++) send(8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 7; i++) send(8'(8'h70 + i), 1'b0);
    idle(3);
    @(negedge sys_clk);
    check("t5_pre_valid", 32'(rd_valid), 32'(1));
    check("t5_pre_data", 32'(rd_data), 32'(8'h60));
    check("t5_pre_full", 32'(bank_full), 32'(2'b01));
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(rd_valid), 32'(0));
    check("t5_rst_data", 32'(rd_data), 32'(0));
    check("t5_rst_full", 32'(bank_full), 32'(0));
    check("t5_rst_wr_bank", 32'(wr_bank), 32'(0));
    idle(2);
    sys_rst  = 1'b0;
    rd_force = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(8'hA0 + i), 1'b0);
    begin
      int t;
      t = 0;
      @(negedge sys_clk);
      while (!rd_valid && t < 10) begin
        t++;
        @(negedge sys_clk);
      end
      check("t5_new_data", 32'(rd_data), 32'(8'hA0));
      check("t5_new_bank", 32'(rd_bank), 32'(0));
      @(posedge sys_clk);
      #1;
    end
    wait_drain(100);

`ifdef PPBUF_PARTIAL_EN
    // 6: an early commit after five words.
    do_reset();
    for (int i = 0; i < 4; i++) send(8'(8'hC0 + i), 1'b0);
    send(8'hC4, 1'b1);
    @(negedge sys_clk);
    check("t6_wr_bank", 32'(wr_bank), 32'(1));
    check("t6_bank_full", 32'(bank_full), 32'(2'b01));
    @(posedge sys_clk);
    #1;
    wait_drain(100);
    check("t6_rd_bank", 32'(rd_bank), 32'(1));
`endif

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
